// File: rtl/eth_rst_seq.sv
// Reset sequencer for an Ethernet PHY and MAC: qualifies PLL lock, pulses the PHY reset,
// waits for the PHY to settle and then releases the MAC. Re-sequences on lock loss or a software request.
module eth_rst_seq #(
    parameter int unsigned LOCK_STABLE_CYC = 16,
    parameter int unsigned PHY_RST_CYC     = 100,
    parameter int unsigned PHY_SETTLE_CYC  = 200,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_rst_req,
    output logic       phy_rst_n,
    output logic       rstn_mac,
    output logic       seq_done,
    output logic       sw_rst_ack,
    output logic [7:0] lock_loss_cnt,
    output logic [1:0] seq_state
);

    localparam logic [1:0] ST_WAIT_LOCK  = 2'd0;
    localparam logic [1:0] ST_PHY_RST    = 2'd1;
    localparam logic [1:0] ST_PHY_SETTLE = 2'd2;
    localparam logic [1:0] ST_RUN        = 2'd3;

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PHY_RST_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PHY_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phy_rst_n_q, phy_rst_n_d;
    logic             rstn_mac_q, rstn_mac_d;
    logic             seq_done_q, seq_done_d;
    logic             ack_q, ack_d;
    logic [7:0]       loss_q, loss_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        loss_d  = loss_q;

        // Lock loss outside WAIT_LOCK outranks everything, including a pending software request.
        if (state_q != ST_WAIT_LOCK && !pll_locked) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            if (loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
            end
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (!pll_locked) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = ST_PHY_RST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_PHY_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_PHY_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_PHY_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d = '0;
                    if (sw_rst_req) begin
                        state_d = ST_PHY_RST;
                        ack_d   = 1'b1;
                    end
                end
            endcase
        end

        phy_rst_n_d = (state_d == ST_PHY_SETTLE) || (state_d == ST_RUN);
        rstn_mac_d  = (state_d == ST_RUN);
        seq_done_d  = (state_d == ST_RUN);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            phy_rst_n_q <= 1'b0;
            rstn_mac_q  <= 1'b0;
            seq_done_q  <= 1'b0;
            ack_q       <= 1'b0;
            loss_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phy_rst_n_q <= phy_rst_n_d;
            rstn_mac_q  <= rstn_mac_d;
            seq_done_q  <= seq_done_d;
            ack_q       <= ack_d;
            loss_q      <= loss_d;
        end
    end

    assign phy_rst_n     = phy_rst_n_q;
    assign rstn_mac      = rstn_mac_q;
    assign seq_done      = seq_done_q;
    assign sw_rst_ack    = ack_q;
    assign lock_loss_cnt = loss_q;
    assign seq_state     = state_q;

endmodule

// File: tb/tb_eth_rst_seq.sv
// Scoreboard bench for eth_rst_seq: an elapsed-time reference model predicts each cycle's outputs,
// a separate monitor pops and compares them one cycle after every rising edge.
module tb_eth_rst_seq;

    localparam int LOCK_CYC   = 16;
    localparam int RST_CYC    = 100;
    localparam int SETTLE_CYC = 200;
    localparam int SEQ_LEN    = RST_CYC + SETTLE_CYC;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       phy_rst_n, rstn_mac, seq_done, sw_rst_ack;
    logic [7:0] lock_loss_cnt;
    logic [1:0] seq_state;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    // Model: either still qualifying lock (streak of locked cycles) or in a sequence,
    // where the phase follows from how many cycles have elapsed since PHY reset began.
    bit mInSeq = 1'b0;
    int mStreak = 0;
    int mElapsed = 0;
    int mLoss = 0;
    bit mAck = 1'b0;

    logic [13:0] expQ[$];

    eth_rst_seq #(
        .LOCK_STABLE_CYC(LOCK_CYC),
        .PHY_RST_CYC(RST_CYC),
        .PHY_SETTLE_CYC(SETTLE_CYC),
        .CNT_W(16)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .pll_locked(pll_locked),
        .sw_rst_req(sw_rst_req),
        .phy_rst_n(phy_rst_n),
        .rstn_mac(rstn_mac),
        .seq_done(seq_done),
        .sw_rst_ack(sw_rst_ack),
        .lock_loss_cnt(lock_loss_cnt),
        .seq_state(seq_state)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [13:0] modelOutputs();
        int phase;
        if (!mInSeq)                    phase = 0;
        else if (mElapsed < RST_CYC)    phase = 1;
        else if (mElapsed < SEQ_LEN)    phase = 2;
        else                            phase = 3;
        return {phase >= 2, phase == 3, phase == 3, mAck, 8'(mLoss), 2'(phase)};
    endfunction

    task automatic modelStep(input bit r, input bit p, input bit q);
        mAck = 1'b0;
        if (r) begin
            mInSeq = 1'b0; mStreak = 0; mElapsed = 0; mLoss = 0;
        end else if (!mInSeq) begin
            mStreak = p ? mStreak + 1 : 0;
            if (mStreak == LOCK_CYC) begin
                mInSeq = 1'b1; mStreak = 0; mElapsed = 0;
            end
        end else if (!p) begin
            mInSeq = 1'b0; mStreak = 0;
            if (mLoss < 255) mLoss++;
        end else if (mElapsed >= SEQ_LEN) begin
            if (q) begin
                mElapsed = 0; mAck = 1'b1;
            end
        end else begin
            mElapsed++;
        end
    endtask

    // Every call covers exactly one rising edge, so the queue stays aligned with the monitor.
    task automatic applyStimulus(input bit r, input bit p, input bit q);
        rst = r; pll_locked = p; sw_rst_req = q;
        modelStep(r, p, q);
        expQ.push_back(modelOutputs());
        @(posedge sys_clk);
        #2;
    endtask

    task automatic checkOutput(input logic [13:0] exp);
        logic [13:0] got;
        got = {phy_rst_n, rstn_mac, seq_done, sw_rst_ack, lock_loss_cnt, seq_state};
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("[TB] FAIL outputs cycle %0d: got phy/mac/done/ack=%b llc=%0d st=%0d, expected phy/mac/done/ack=%b llc=%0d st=%0d",
                         cycle, got[13:10], got[9:2], got[1:0], exp[13:10], exp[9:2], exp[1:0]);
        end
    endtask

    task automatic runLocked(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    // Hold the request until the model acknowledges it, then drop it.
    task automatic requestUntilAck(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            seen = mAck;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL sw_ack_timeout: got no ack within %0d cycles, expected ack", budget);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    always @(posedge sys_clk) begin
        cycle++;
        #1;
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        bit reqHeld;
        $display("[TB] eth_rst_seq scoreboard bench starting");

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        runLocked(330);

        applyStimulus(1'b1, 1'b0, 1'b0);
        runLocked(10);
        applyStimulus(1'b0, 1'b0, 1'b0);
        runLocked(330);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        runLocked(330);

        requestUntilAck(5);
        runLocked(150);
        requestUntilAck(400);
        runLocked(310);

        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            runLocked(LOCK_CYC);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end

        runLocked(LOCK_CYC + RST_CYC + 50);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runLocked(5);

        reqHeld = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!reqHeld && $urandom_range(0, 99) == 0) reqHeld = 1'b1;
            applyStimulus($urandom_range(0, 799) == 0, $urandom_range(0, 149) != 0, reqHeld);
            if (mAck) reqHeld = 1'b0;
        end
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_rst_seq.md
Name: eth_rst_seq

Overview:
- Single-clock reset sequencer in the sys_clk domain. It sits downstream of the PLL/reset synchroniser and drives the external Ethernet PHY hard reset and the MAC-side reset.
- It qualifies PLL lock with a stability window, pulses the PHY reset, and waits the PHY settle time before releasing the MAC.
- It re-sequences on lock loss or on a software reset request, and exposes status counters for debug.

Parameters:
LOCK_STABLE_CYC, 16, consecutive cycles pll_locked must be high before sequencing starts (>=1)
PHY_RST_CYC, 100, cycles phy_rst_n is held low (>=1)
PHY_SETTLE_CYC, 200, cycles from phy_rst_n release to rstn_mac release (>=1)
CNT_W, 16, width of the shared phase counter; must hold max(params)-1

Ports:
sys_clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL lock, already synchronised to sys_clk
sw_rst_req  in  1  software re-sequence request (level, held until ack)
phy_rst_n  out  1  PHY hard reset, active-low
rstn_mac  out  1  MAC/datapath reset, active-low
seq_done  out  1  high while in RUN
sw_rst_ack  out  1  one-cycle acknowledge of sw_rst_req
lock_loss_cnt  out  8  lock-loss events since rst, saturating
seq_state  out  2  state: 0 WAIT_LOCK, 1 PHY_RST, 2 PHY_SETTLE, 3 RUN

Behaviour:
- All outputs are registered and update on the same edge as the state transition that defines them.
- Reset (rst=1, checked before any other condition):
  - state=WAIT_LOCK, cnt=0.
  - phy_rst_n=0, rstn_mac=0, seq_done=0, sw_rst_ack=0, lock_loss_cnt=0.
  - rst asserted mid-sequence aborts immediately, with no completion of the current phase.
- WAIT_LOCK: phy_rst_n=0, rstn_mac=0.
  - pll_locked=1: cnt increments.
  - pll_locked=0: cnt clears to 0.
  - On the edge where pll_locked=1 and cnt==LOCK_STABLE_CYC-1: go to PHY_RST, cnt=0.
- PHY_RST: phy_rst_n=0, rstn_mac=0, cnt increments.
  - At cnt==PHY_RST_CYC-1: go to PHY_SETTLE, cnt=0, phy_rst_n=1.
- PHY_SETTLE: phy_rst_n=1, rstn_mac=0, cnt increments.
  - At cnt==PHY_SETTLE_CYC-1: go to RUN, rstn_mac=1, seq_done=1.
- RUN: phy_rst_n=1, rstn_mac=1, seq_done=1, cnt held at 0.
- Lock loss: pll_locked=0 in PHY_RST, PHY_SETTLE or RUN means on the next edge:
  - state=WAIT_LOCK, cnt=0, phy_rst_n=0, rstn_mac=0, seq_done=0.
  - lock_loss_cnt increments, saturating at 255.
  - Lock loss in WAIT_LOCK is not counted.
- Software request: sw_rst_req=1 while in RUN with pll_locked=1 means on the next edge:
  - state=PHY_RST, cnt=0, phy_rst_n=0, rstn_mac=0, seq_done=0, sw_rst_ack=1 for exactly one cycle.
  - PLL lock is not re-qualified.
  - In any other state the request is not acted on and not latched; it is served when RUN is reached, provided it is still held.
  - The requester drops sw_rst_req in the cycle after it sees ack.
  - If sw_rst_req is still high in the cycle after the ack, the block is in PHY_RST and ignores it. A request still held when RUN is re-entered triggers a new sequence.
- Simultaneous events: lock loss has priority over sw_rst_req. With pll_locked=0 and sw_rst_req=1 in RUN, the block goes to WAIT_LOCK, sw_rst_ack stays 0, and lock_loss_cnt increments.
- Counter compares are equality on CNT_W bits; cnt never wraps in normal operation.

Latency, all counts in cycles and measured from the first edge with rst=0 and pll_locked=1 held:
- PHY_RST entered after LOCK_STABLE_CYC.
- phy_rst_n rises after LOCK_STABLE_CYC+PHY_RST_CYC.
- rstn_mac rises after LOCK_STABLE_CYC+PHY_RST_CYC+PHY_SETTLE_CYC.

Test Plan:
1. Clean power-up: apply rst for 5 cycles, then pll_locked=1 steady -> seq_state 0→1 at cycle 16, phy_rst_n rises at cycle 116, rstn_mac and seq_done rise at cycle 316, lock_loss_cnt=0.
2. Lock glitch in WAIT_LOCK: pll_locked high 10 cycles, low 1 cycle, then high -> stability window restarts; PHY_RST entered 16 cycles after the re-rise; lock_loss_cnt stays 0.
3. Lock loss in RUN: drop pll_locked for 3 cycles -> next edge phy_rst_n=0, rstn_mac=0, seq_done=0, seq_state=0, lock_loss_cnt=1. After re-lock the full 316-cycle sequence repeats.
4. Software reset: in RUN raise sw_rst_req until ack -> sw_rst_ack high one cycle on the edge seq_state=1; phy_rst_n rises 100 cycles later and rstn_mac 200 cycles after that. Repeat with the request raised during PHY_SETTLE -> no ack until RUN, then ack on the first RUN cycle.
5. Collision and saturation:
   - sw_rst_req=1 and pll_locked=0 on the same cycle in RUN -> WAIT_LOCK, no ack, lock_loss_cnt increments.
   - 300 lock-loss events -> lock_loss_cnt stays at 255.
6. rst mid-sequence: assert rst during PHY_SETTLE -> next edge all outputs at reset values, lock_loss_cnt=0, seq_state=0.
